// File: rtl/branch_ctrl.sv
// Decode-stage zero-compare branch sequencer: waits for RD1, resolves the six single-operand
// branch types, issues the fetch redirect and covers the delay slot. Keeps taken/not-taken stats.
module branch_ctrl #(
  parameter int unsigned WAIT_LIMIT = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic [31:0]      br_target,
  input  logic             opnd_ready,
  input  logic [1:0]       br_judge,
  output logic             stall,
  output logic             br_done,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             slot_active,
  output logic             timeout,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt
);

  localparam int unsigned WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResolve, StSlot} state_e;

  state_e           state_q;
  logic [2:0]       type_q;
  logic [1:0]       judge_q;
  logic [31:0]      target_q;
  logic [WW-1:0]    wait_cnt_q;
  logic             br_done_q;
  logic             redirect_valid_q;
  logic             slot_active_q;
  logic             timeout_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] nt_cnt_q;

  // Judge code 11 (invalid or forced by timeout) never takes.
  function automatic logic is_taken(input logic [2:0] t, input logic [1:0] j);
    logic res;
    res = 1'b0;
    if (j != 2'b11) begin
      case (t)
        3'b000:  res = (j == 2'b00);
        3'b001:  res = (j == 2'b01) || (j == 2'b10);
        3'b010:  res = (j == 2'b00) || (j == 2'b10);
        3'b011:  res = (j == 2'b01);
        3'b100:  res = (j == 2'b10);
        3'b101:  res = (j == 2'b00) || (j == 2'b01);
        default: res = 1'b0;
      endcase
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      type_q           <= '0;
      judge_q          <= '0;
      target_q         <= '0;
      wait_cnt_q       <= '0;
      br_done_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      slot_active_q    <= 1'b0;
      timeout_q        <= 1'b0;
      taken_cnt_q      <= '0;
      nt_cnt_q         <= '0;
    end else begin
      br_done_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      slot_active_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (br_valid) begin
            type_q   <= br_type;
            target_q <= br_target;
            if (opnd_ready) begin
              judge_q          <= br_judge;
              state_q          <= StResolve;
              br_done_q        <= 1'b1;
              redirect_valid_q <= is_taken(br_type, br_judge);
            end else begin
              wait_cnt_q <= '0;
              state_q    <= StWait;
            end
          end
        end
        StWait: begin
          if (opnd_ready) begin
            judge_q          <= br_judge;
            state_q          <= StResolve;
            br_done_q        <= 1'b1;
            redirect_valid_q <= is_taken(type_q, br_judge);
          end else if (wait_cnt_q == WW'(WAIT_LIMIT - 1)) begin
            judge_q   <= 2'b11;
            timeout_q <= 1'b1;
            state_q   <= StResolve;
            br_done_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
        end
        StResolve: begin
          if (is_taken(type_q, judge_q)) begin
            if (taken_cnt_q != {CNT_W{1'b1}}) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            slot_active_q <= 1'b1;
            state_q       <= StSlot;
          end else begin
            if (nt_cnt_q != {CNT_W{1'b1}}) nt_cnt_q <= nt_cnt_q + CNT_W'(1);
            state_q <= StIdle;
          end
        end
        StSlot:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RESOLVE never stalls: br_done is always high there, so the branch retires that cycle.
  assign stall          = ((state_q == StIdle) && br_valid) || (state_q == StWait);
  assign br_done        = br_done_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = target_q;
  assign slot_active    = slot_active_q;
  assign timeout        = timeout_q;
  assign taken_cnt      = taken_cnt_q;
  assign nt_cnt         = nt_cnt_q;

endmodule
